// File: rtl/alu_if.sv
// Operand/result bundle for the ALU-MP execution block.
interface alu_if;
  logic [5:0]  opcode;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;

  modport master (output opcode, output a, output b, input result);
  modport slave  (input opcode, input a, input b, output result);
endinterface

// File: rtl/alu.sv
// Registered 32-bit signed ALU, one-cycle latency, one operation per cycle.
// Logic opcodes (~a, or, and, xor) exist only when ALU_LOGIC_OPS_EN is defined.
module alu (
  input  logic clk,
  input  logic rst,
  alu_if.slave bus
);

  localparam logic [5:0] OP_ADD = 6'd4;
  localparam logic [5:0] OP_SUB = 6'd14;
  localparam logic [5:0] OP_ABS = 6'd8;
  localparam logic [5:0] OP_NEG = 6'd11;
  localparam logic [5:0] OP_MAX = 6'd7;
  localparam logic [5:0] OP_MIN = 6'd1;
  localparam logic [5:0] OP_AVG = 6'd13;
`ifdef ALU_LOGIC_OPS_EN
  localparam logic [5:0] OP_NOT = 6'd15;
  localparam logic [5:0] OP_OR  = 6'd3;
  localparam logic [5:0] OP_AND = 6'd5;
  localparam logic [5:0] OP_XOR = 6'd2;
`endif

  logic [31:0] result_d;
  logic [31:0] result_q;
  logic [32:0] sum_ext_s;
  logic        a_gt_b_s;

  // 33-bit sum keeps the carry so avg never overflows; >>>1 rounds toward -inf.
  assign sum_ext_s = {bus.a[31], bus.a} + {bus.b[31], bus.b};
  assign a_gt_b_s  = $signed(bus.a) > $signed(bus.b);

  // Operation select
  always_comb begin
    result_d = 32'd0;
    case (bus.opcode)
      OP_ADD:  result_d = bus.a + bus.b;
      OP_SUB:  result_d = bus.a - bus.b;
      OP_ABS:  result_d = bus.a[31] ? (32'd0 - bus.a) : bus.a;
      OP_NEG:  result_d = 32'd0 - bus.a;
      OP_MAX:  result_d = a_gt_b_s ? bus.a : bus.b;
      OP_MIN:  result_d = a_gt_b_s ? bus.b : bus.a;
      OP_AVG:  result_d = sum_ext_s[32:1];
`ifdef ALU_LOGIC_OPS_EN
      OP_NOT:  result_d = ~bus.a;
      OP_OR:   result_d = bus.a | bus.b;
      OP_AND:  result_d = bus.a & bus.b;
      OP_XOR:  result_d = bus.a ^ bus.b;
`endif
      default: result_d = 32'd0;
    endcase
  end

  // Result register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= 32'd0;
    end else begin
      result_q <= result_d;
    end
  end

  assign bus.result = result_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; logic-op expectations follow ALU_LOGIC_OPS_EN.
module tb_alu;

  logic clk;
  logic rst;
  int   checks;
  int   passed;

  alu_if bus ();

  alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv);
    bus.opcode = op;
    bus.a      = av;
    bus.b      = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(6'd4, 32'h1234_5678, 32'h1111_1111);
    drive(6'd4, 32'h1234_5678, 32'h1111_1111);
    checks++;
    if (bus.result !== 32'h0000_0000)
      $display("FAIL reset_state: got %h expected %h", bus.result, 32'h0000_0000);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_arith;
    logic [31:0] exp_v [4];
    logic [5:0]  ops   [4];
    exp_v = '{32'h0000_4B60, 32'h0000_33FC, 32'h0000_3FAE, 32'hFFFF_C052};
    ops   = '{6'd4, 6'd14, 6'd8, 6'd11};
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], 32'h0000_3FAE, 32'h0000_0BB2);
      checks++;
      if (bus.result !== exp_v[i])
        $display("FAIL arith op%0d: got %h expected %h", ops[i], bus.result, exp_v[i]);
      else passed++;
    end
  endtask

  task automatic test_minmax_avg;
    logic [31:0] exp_v [3];
    logic [5:0]  ops   [3];
    exp_v = '{32'd16302, 32'd2994, 32'd9648};
    ops   = '{6'd7, 6'd1, 6'd13};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], 32'h0000_3FAE, 32'h0000_0BB2);
      checks++;
      if (bus.result !== exp_v[i])
        $display("FAIL minmax_avg op%0d: got %h expected %h", ops[i], bus.result, exp_v[i]);
      else passed++;
    end
    // Signed compare: negative a must lose max and win min
    drive(6'd7, 32'hFFFF_FFF0, 32'h0000_0005);
    checks++;
    if (bus.result !== 32'h0000_0005)
      $display("FAIL max_signed: got %h expected %h", bus.result, 32'h0000_0005);
    else passed++;
    drive(6'd1, 32'hFFFF_FFF0, 32'h0000_0005);
    checks++;
    if (bus.result !== 32'hFFFF_FFF0)
      $display("FAIL min_signed: got %h expected %h", bus.result, 32'hFFFF_FFF0);
    else passed++;
  endtask

  task automatic test_boundary;
    drive(6'd4, 32'h7FFF_FFFF, 32'h0000_0001);
    checks++;
    if (bus.result !== 32'h8000_0000)
      $display("FAIL add_wrap: got %h expected %h", bus.result, 32'h8000_0000);
    else passed++;
    drive(6'd8, 32'h8000_0000, 32'h0000_0000);
    checks++;
    if (bus.result !== 32'h8000_0000)
      $display("FAIL abs_min: got %h expected %h", bus.result, 32'h8000_0000);
    else passed++;
    drive(6'd11, 32'h8000_0000, 32'h0000_0000);
    checks++;
    if (bus.result !== 32'h8000_0000)
      $display("FAIL neg_min: got %h expected %h", bus.result, 32'h8000_0000);
    else passed++;
    drive(6'd13, 32'hFFFF_FFFD, 32'h0000_0000);
    checks++;
    if (bus.result !== 32'hFFFF_FFFE)
      $display("FAIL avg_neg: got %h expected %h", bus.result, 32'hFFFF_FFFE);
    else passed++;
    drive(6'd13, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    checks++;
    if (bus.result !== 32'h7FFF_FFFF)
      $display("FAIL avg_no_ovf: got %h expected %h", bus.result, 32'h7FFF_FFFF);
    else passed++;
  endtask

  task automatic test_logic;
    logic [31:0] exp_v [4];
    logic [5:0]  ops   [4];
    ops = '{6'd3, 6'd5, 6'd2, 6'd15};
`ifdef ALU_LOGIC_OPS_EN
    exp_v = '{32'hFFF0_FFF0, 32'h00F0_00F0, 32'hFF00_FF00, 32'h0F0F_0F0F};
`else
    exp_v = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
`endif
    for (int i = 0; i < 4; i++) begin
      drive(6'd4, 32'h0000_0001, 32'h0000_0001);
      drive(ops[i], 32'hF0F0_F0F0, 32'h0FF0_0FF0);
      checks++;
      if (bus.result !== exp_v[i])
        $display("FAIL logic op%0d: got %h expected %h", ops[i], bus.result, exp_v[i]);
      else passed++;
    end
  endtask

  task automatic test_invalid;
    drive(6'd4, 32'h0000_0010, 32'h0000_0020);
    drive(6'd63, 32'h0000_0010, 32'h0000_0020);
    checks++;
    if (bus.result !== 32'h0000_0000)
      $display("FAIL opcode63: got %h expected %h", bus.result, 32'h0000_0000);
    else passed++;
  endtask

  task automatic test_hold_between_edges;
    drive(6'd4, 32'h0000_0100, 32'h0000_0023);
    bus.opcode = 6'd14;
    bus.a      = 32'h0000_0000;
    bus.b      = 32'h0000_0001;
    #2;
    checks++;
    if (bus.result !== 32'h0000_0123)
      $display("FAIL hold: got %h expected %h", bus.result, 32'h0000_0123);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if (bus.result !== 32'hFFFF_FFFF)
      $display("FAIL back_to_back: got %h expected %h", bus.result, 32'hFFFF_FFFF);
    else passed++;
  endtask

  task automatic test_reset_midstream;
    drive(6'd4, 32'h0000_0005, 32'h0000_0006);
    rst = 1'b1;
    drive(6'd4, 32'h0000_0007, 32'h0000_0008);
    checks++;
    if (bus.result !== 32'h0000_0000)
      $display("FAIL reset_mid: got %h expected %h", bus.result, 32'h0000_0000);
    else passed++;
    rst = 1'b0;
    drive(6'd4, 32'h0000_0007, 32'h0000_0008);
    checks++;
    if (bus.result !== 32'h0000_000F)
      $display("FAIL reset_release: got %h expected %h", bus.result, 32'h0000_000F);
    else passed++;
  endtask

  initial begin
    checks     = 0;
    passed     = 0;
    rst        = 1'b1;
    bus.opcode = 6'd0;
    bus.a      = 32'd0;
    bus.b      = 32'd0;
    test_reset();
    test_arith();
    test_minmax_avg();
    test_boundary();
    test_logic();
    test_invalid();
    test_hold_between_edges();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
